// File: rtl/fetch_unit_pkg.sv
// Shared encodings, instruction field positions and defaults for the fetch / next-PC stage.
package fetch_unit_pkg;

    localparam logic [31:0] DefaultResetPc   = 32'h0000_3000;
    localparam logic [31:0] DefaultIsrVector = 32'h0000_4180;

    localparam int unsigned Imm16Msb  = 15;
    localparam int unsigned Imm16Lsb  = 0;
    localparam int unsigned Addr26Msb = 25;
    localparam int unsigned Addr26Lsb = 0;

    typedef enum logic [1:0] {
        PcIncStop   = 2'd0,
        PcIncNormal = 2'd1,
        PcIncBranch = 2'd2,
        PcIncJump   = 2'd3
    } pc_inc_e;

    typedef enum logic {
        PcJumpImme = 1'b0,
        PcJumpReg  = 1'b1
    } pc_jump_e;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StIsr  = 2'd1,
        StHalt = 2'd2
    } state_e;

    // Branch displacement in bytes: sign-extended word offset.
    function automatic logic [31:0] branch_offset(input logic [31:0] ins);
        return {{14{ins[Imm16Msb]}}, ins[Imm16Msb:Imm16Lsb], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection from the decoder's PC_INC / PC_JUMP fields.
module fetch_unit_npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] ins_i,
    input  logic [1:0]  pc_inc_i,
    input  logic        pc_jump_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jump_reg_data_i,
    output logic [31:0] npc_o,
    output logic [31:0] seq_o
);

    logic unused_bits;
    assign unused_bits = ^{ins_i[31:26], jump_reg_data_i[1:0]};

    always_comb begin
        seq_o = pc_i + 32'd4;
        npc_o = seq_o;
        unique case (pc_inc_e'(pc_inc_i))
            PcIncStop:   npc_o = pc_i;
            PcIncNormal: npc_o = seq_o;
            PcIncBranch: begin
                if (branch_taken_i) begin
                    npc_o = seq_o + branch_offset(ins_i);
                end
            end
            PcIncJump: begin
                if (pc_jump_e'(pc_jump_i) == PcJumpReg) begin
                    npc_o = {jump_reg_data_i[31:2], 2'b00};
                end else begin
                    npc_o = {seq_o[31:28], ins_i[Addr26Msb:Addr26Lsb], 2'b00};
                end
            end
            default: npc_o = seq_o;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC/EPC registers, RUN/ISR/HALT control and the interrupt request latch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefaultResetPc,
    parameter logic [31:0] ISR_VECTOR = DefaultIsrVector
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic [1:0]  pc_inc_i,
    input  logic        pc_jump_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jump_reg_data_i,
    input  logic        eret_i,
    input  logic        irq_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] epc_o,
    output logic        halted_o,
    output logic        in_isr_o
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic        irq_pend_q;
    logic        halted_q;
    logic        in_isr_q;

    logic [31:0] npc;
    logic [31:0] seq;
    logic [31:0] run_tgt;
    logic        is_stop;
    logic        irq_take;

    fetch_unit_npc_calc u_npc_calc (
        .pc_i            (pc_q),
        .ins_i           (imem_rdata_i),
        .pc_inc_i        (pc_inc_i),
        .pc_jump_i       (pc_jump_i),
        .branch_taken_i  (branch_taken_i),
        .jump_reg_data_i (jump_reg_data_i),
        .npc_o           (npc),
        .seq_o           (seq)
    );

    always_comb begin
        is_stop  = (pc_inc_e'(pc_inc_i) == PcIncStop);
        // eret outside an ISR behaves as a plain sequential instruction.
        run_tgt  = eret_i ? seq : npc;
        irq_take = irq_pend_q | irq_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            epc_q      <= 32'd0;
            irq_pend_q <= 1'b0;
            halted_q   <= 1'b0;
            in_isr_q   <= 1'b0;
        end else begin
            if (irq_i && state_q != StHalt) begin
                irq_pend_q <= 1'b1;
            end
            if (!stall_i) begin
                unique case (state_q)
                    StRun: begin
                        if (is_stop) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else if (irq_take) begin
                            epc_q      <= run_tgt;
                            pc_q       <= ISR_VECTOR;
                            state_q    <= StIsr;
                            in_isr_q   <= 1'b1;
                            irq_pend_q <= 1'b0;
                        end else begin
                            pc_q <= run_tgt;
                        end
                    end
                    StIsr: begin
                        if (eret_i) begin
                            pc_q     <= epc_q;
                            state_q  <= StRun;
                            in_isr_q <= 1'b0;
                        end else if (is_stop) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                            in_isr_q <= 1'b0;
                        end else begin
                            pc_q <= npc;
                        end
                    end
                    StHalt: begin
                    end
                    default: begin
                        state_q <= StHalt;
                    end
                endcase
            end
        end
    end

    assign imem_addr_o = pc_q;
    assign ins_o       = imem_rdata_i;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = seq;
    assign epc_o       = epc_q;
    assign halted_o    = halted_q;
    assign in_isr_o    = in_isr_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and next-PC stage of the single-cycle MIPS core. It sits directly upstream of the instruction decoder.
- Holds the PC and drives the instruction-memory address.
- Presents the fetched word to the decoder.
- Consumes the decoder's PC_INC/PC_JUMP/eret fields plus the ALU branch result to select the next PC.
- Adds a halt state and single-level interrupt entry/return (EPC).

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
ISR_VECTOR, 32'h0000_4180, interrupt handler entry address

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  memory wait; holds all state when high (rst still wins)
pc_inc  in  2  decoder PC_INC field: STOP / NORMAL / BRANCH / JUMP
pc_jump  in  1  decoder PC_JUMP field: IMME / REG
branch_taken  in  1  ALU branch-condition result for the current instruction
jump_reg_data  in  32  rs value for jr
eret  in  1  decoder eret flag
irq  in  1  external interrupt request, level or single-cycle pulse
imem_addr  out  32  = pc (combinational)
imem_rdata  in  32  instruction word at imem_addr, same cycle
ins  out  32  = imem_rdata, forwarded to the decoder
pc  out  32  current PC
pc_plus4  out  32  pc+4, used for the jal link write
epc  out  32  saved return PC
halted  out  1  high in HALT
in_isr  out  1  high in ISR

Behaviour:
Reset (rst=1 at clock edge):
- pc=RESET_PC, epc=0, state=RUN, irq_pending=0.
- Outputs: halted=0, in_isr=0.
- rst overrides stall, irq and everything else, including mid-ISR and in HALT.

Next-PC (npc), all arithmetic mod 2^32, where seq = pc+4:
- NORMAL: seq.
- BRANCH: if branch_taken, seq + (sign_ext(ins[15:0]) << 2); otherwise seq.
- JUMP with pc_jump=IMME: {seq[31:28], ins[25:0], 2'b00}.
- JUMP with pc_jump=REG: {jump_reg_data[31:2], 2'b00}; low bits are silently cleared.
- STOP: pc.

irq_pending:
- Set on any cycle with irq=1.
- Cleared only when the interrupt is taken or on rst.

State machine (RUN, ISR, HALT), evaluated when stall=0:
- RUN with pc_inc=STOP: go to HALT, pc unchanged. STOP has priority over a pending irq.
- RUN with irq_pending (set, or irq=1 this cycle) and pc_inc≠STOP:
  - epc <= npc, pc <= ISR_VECTOR, go to ISR, clear irq_pending.
  - The current instruction completes normally; only its successor is redirected.
- RUN otherwise: pc <= npc. eret in RUN is treated as a NOP (pc <= seq).
- ISR with eret=1: pc <= epc, go to RUN.
  - A pending irq is serviced on the first RUN instruction after return, not on the eret edge itself.
- ISR with pc_inc=STOP: go to HALT.
- ISR otherwise: pc <= npc. irq is latched but not serviced (no nesting).
- HALT: pc, epc and pending state frozen; irq is ignored for servicing. Exit only via rst.

Other rules:
- stall=1: pc, epc, state and irq_pending hold. An irq pulse arriving during stall is still latched.
- halted = (state==HALT); in_isr = (state==ISR). Both are registered state decodes, so they change the cycle after the triggering edge.
- Fetch latency is zero: ins follows pc combinationally.

Decomposition:
- Shared package/defines:
  - PC_INC encodings: STOP, NORMAL, BRANCH, JUMP.
  - PC_JUMP encodings: IMME, REG.
  - Instruction field ranges for imm16 and addr26.
  - Default RESET_PC and ISR_VECTOR.
  - State typedef {RUN, ISR, HALT}.
- One combinational sub-module, npc_calc: inputs pc, ins, pc_inc, pc_jump, branch_taken, jump_reg_data; outputs npc and seq.
- fetch_unit keeps the state machine, PC/EPC registers and irq latch.

Test Plan:
- Reset, then NORMAL for 3 cycles: pc = 0x3000 → 0x3004 → 0x3008; ins equals memory word at each address; halted=0, in_isr=0.
- Branch at pc=0x3008 with imm=0xFFFF: taken → pc=0x3008; not taken → pc=0x300C. With imm=0x0004, taken → pc=0x301C.
- Jumps at pc=0x3010:
  - IMME with ins[25:0]=0x0000C10 → pc=0x00003040; pc_plus4=0x3014 during the jal cycle.
  - REG with jump_reg_data=0x00003007 → pc=0x00003004.
- Interrupt cycle:
  - 1-cycle irq pulse while stall=1, then NORMAL at pc=0x3004 → pc=0x4180, epc=0x3008, in_isr=1.
  - Second irq inside the ISR is held pending.
  - eret → pc=0x3008, in_isr=0; the next edge vectors to 0x4180 with epc=0x300C.
- STOP together with irq: STOP wins → halted=1, pc frozen for 10 cycles, irq ignored. rst then gives pc=0x3000, halted=0.
- Reset mid-ISR (in_isr=1, epc≠0): after rst, pc=0x3000, epc=0, in_isr=0, and a previously pending irq is discarded.
